// File: rtl/ieeedrv_sd_arb.sv
// ieeedrv_sd_arb -- round-robin arbiter sharing one MiSTer-style SD block
// port (lba/blk_cnt/rd/wr/ack/buffer) among NBD drive sub-units.
//
// Flow per transfer: IDLE picks the next pending unit by rotation, ISSUE
// holds the host request until the first ack, XFER routes ack and write
// data to the granted unit while ack stays high, and RELEASE advances the
// rotation pointer and gives the unit one cycle to drop its request.
//
// Optional build macro SD_ARB_TIMEOUT_EN adds a TMO_W-bit watchdog on
// ISSUE. When the watchdog reaches all-ones, the host request is dropped,
// timeout pulses for one cycle and the arbiter moves on. Without the
// macro, ISSUE waits forever and timeout is tied low.

module ieeedrv_sd_arb #(
    parameter int NBD   = 2,
    parameter int TMO_W = 24
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic [32*NBD-1:0]   req_lba,
    input  logic [6*NBD-1:0]    req_blk_cnt,
    input  logic [NBD-1:0]      req_rd,
    input  logic [NBD-1:0]      req_wr,
    output logic [NBD-1:0]      req_ack,
    input  logic [8*NBD-1:0]    req_buff_din,
    output logic [31:0]         sd_lba,
    output logic [5:0]          sd_blk_cnt,
    output logic                sd_rd,
    output logic                sd_wr,
    input  logic                sd_ack,
    output logic [7:0]          sd_buff_din,
    output logic [NBD-1:0]      grant,
    output logic                busy,
    output logic                timeout
);

    // Index width for unit numbers; at least one bit so NBD=1 still builds.
    localparam int PW = (NBD > 1) ? $clog2(NBD) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Registered state
    state_t             r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_gidx;
    logic [NBD-1:0]     r_grant;
    logic [31:0]        r_lba;
    logic [5:0]         r_blk;
    logic               r_rd;
    logic               r_wr;
    logic               r_busy;

    // Next-state values
    state_t             w_state_nxt;
    logic [PW-1:0]      w_ptr_nxt;
    logic [PW-1:0]      w_gidx_nxt;
    logic [NBD-1:0]     w_grant_nxt;
    logic [31:0]        w_lba_nxt;
    logic [5:0]         w_blk_nxt;
    logic               w_rd_nxt;
    logic               w_wr_nxt;
    logic               w_busy_nxt;

    // Arbitration helpers
    logic [NBD-1:0]     w_pending;
    logic               w_found;
    logic [PW-1:0]      w_sel;
    logic               w_active;

`ifdef SD_ARB_TIMEOUT_EN
    logic [TMO_W-1:0]   r_cnt;
    logic [TMO_W-1:0]   w_cnt_nxt;
    logic               r_timeout;
    logic               w_timeout_nxt;
`endif

    // (a + k) mod NBD, valid because both a and k are below NBD.
    function automatic logic [PW-1:0] f_wrap_add(input logic [PW-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= NBD) begin
            s = s - NBD;
        end else begin
            s = s;
        end
        return s[PW-1:0];
    endfunction

    assign w_pending = req_rd | req_wr;

    // Rotating search: first pending unit at or after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        for (int k = 0; k < NBD; k++) begin
            if (!w_found && w_pending[f_wrap_add(r_ptr, k)]) begin
                w_found = 1'b1;
                w_sel   = f_wrap_add(r_ptr, k);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Next-state and next-output logic of the arbitration FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gidx_nxt  = r_gidx;
        w_grant_nxt = r_grant;
        w_lba_nxt   = r_lba;
        w_blk_nxt   = r_blk;
        w_rd_nxt    = r_rd;
        w_wr_nxt    = r_wr;
`ifdef SD_ARB_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_ISSUE;
                    w_gidx_nxt  = w_sel;
                    w_grant_nxt = NBD'(1) << w_sel;
                    w_lba_nxt   = req_lba[32*w_sel +: 32];
                    w_blk_nxt   = req_blk_cnt[6*w_sel +: 6];
                    // Read wins when a unit raises both directions.
                    w_rd_nxt    = req_rd[w_sel];
                    w_wr_nxt    = ~req_rd[w_sel] & req_wr[w_sel];
`ifdef SD_ARB_TIMEOUT_EN
                    w_cnt_nxt   = {TMO_W{1'b0}};
`endif
                end else begin
                    w_grant_nxt = {NBD{1'b0}};
                    w_rd_nxt    = 1'b0;
                    w_wr_nxt    = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (sd_ack) begin
                    // Host has taken the request; drop it and follow ack.
                    w_rd_nxt    = 1'b0;
                    w_wr_nxt    = 1'b0;
                    w_state_nxt = ST_XFER;
                end else begin
`ifdef SD_ARB_TIMEOUT_EN
                    if (r_cnt == {TMO_W{1'b1}}) begin
                        // Host never answered: abandon and rotate onwards.
                        w_rd_nxt      = 1'b0;
                        w_wr_nxt      = 1'b0;
                        w_timeout_nxt = 1'b1;
                        w_state_nxt   = ST_RELEASE;
                    end else begin
                        w_cnt_nxt     = r_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
                    end
`else
                    w_state_nxt = ST_ISSUE;
`endif
                end
            end
            ST_XFER: begin
                if (!sd_ack) begin
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_RELEASE: begin
                // Next search starts just past the unit that was served.
                w_ptr_nxt   = (r_gidx == PW'(NBD-1)) ? {PW{1'b0}} : (r_gidx + {{(PW-1){1'b0}}, 1'b1});
                w_grant_nxt = {NBD{1'b0}};
                w_rd_nxt    = 1'b0;
                w_wr_nxt    = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = {NBD{1'b0}};
                w_rd_nxt    = 1'b0;
                w_wr_nxt    = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and output registers; reset drops the host request immediately.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= {PW{1'b0}};
            r_gidx  <= {PW{1'b0}};
            r_grant <= {NBD{1'b0}};
            r_lba   <= 32'h0000_0000;
            r_blk   <= 6'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gidx  <= w_gidx_nxt;
            r_grant <= w_grant_nxt;
            r_lba   <= w_lba_nxt;
            r_blk   <= w_blk_nxt;
            r_rd    <= w_rd_nxt;
            r_wr    <= w_wr_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    // Watchdog counter and its one-cycle abort pulse.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= {TMO_W{1'b0}};
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end
    assign timeout = r_timeout;
`else
    // The watchdog width only matters when the watchdog is built.
    assign timeout = (TMO_W > 0) ? 1'b0 : 1'b0;
`endif

    // Ack and write data only flow while a grant is live on the host side.
    assign w_active    = (r_state == ST_ISSUE) || (r_state == ST_XFER);
    assign req_ack     = (w_active && sd_ack) ? r_grant : {NBD{1'b0}};
    assign sd_buff_din = w_active ? req_buff_din[8*r_gidx +: 8] : 8'h00;

    assign sd_lba      = r_lba;
    assign sd_blk_cnt  = r_blk;
    assign sd_rd       = r_rd;
    assign sd_wr       = r_wr;
    assign grant       = r_grant;
    assign busy        = r_busy;

endmodule

// File: tb/tb_ieeedrv_sd_arb.sv
// Directed testbench for ieeedrv_sd_arb (NBD=2, watchdog not built).
module tb_ieeedrv_sd_arb;

    logic         clk_sys = 1'b0;
    logic         reset_n;
    logic [63:0]  req_lba;
    logic [11:0]  req_blk_cnt;
    logic [1:0]   req_rd;
    logic [1:0]   req_wr;
    logic [1:0]   req_ack;
    logic [15:0]  req_buff_din;
    logic [31:0]  sd_lba;
    logic [5:0]   sd_blk_cnt;
    logic         sd_rd;
    logic         sd_wr;
    logic         sd_ack;
    logic [7:0]   sd_buff_din;
    logic [1:0]   grant;
    logic         busy;
    logic         timeout;

    int n_tests = 0;
    int n_fail  = 0;

    ieeedrv_sd_arb #(.NBD(2), .TMO_W(24)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .req_lba      (req_lba),
        .req_blk_cnt  (req_blk_cnt),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_ack      (req_ack),
        .req_buff_din (req_buff_din),
        .sd_lba       (sd_lba),
        .sd_blk_cnt   (sd_blk_cnt),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_din  (sd_buff_din),
        .grant        (grant),
        .busy         (busy),
        .timeout      (timeout)
    );

    // 100 MHz system clock
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for a grant, check it, run a 3-cycle host ack and wait for IDLE.
    task automatic do_xfer(input string tag, input logic [1:0] eg, input logic erd,
                           input logic ewr, input logic [7:0] edin, input logic [1:0] drop);
        int n;
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_grant"}, 32'(grant), 32'(eg));
        chk({tag, "_rd"}, 32'(sd_rd), 32'(erd));
        chk({tag, "_wr"}, 32'(sd_wr), 32'(ewr));
        sd_ack = 1'b1;
        #1;
        chk({tag, "_ack"}, 32'(req_ack), 32'(eg));
        chk({tag, "_din"}, 32'(sd_buff_din), 32'(edin));
        req_rd = req_rd & ~drop;
        req_wr = req_wr & ~drop;
        repeat (3) @(negedge clk_sys);
        sd_ack = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "tb timeout");
    end

    initial begin
        reset_n      = 1'b0;
        req_lba      = 64'h0;
        req_blk_cnt  = 12'h0;
        req_rd       = 2'b00;
        req_wr       = 2'b00;
        sd_ack       = 1'b0;
        req_buff_din = 16'h0000;
        repeat (3) @(negedge clk_sys);

        // Reset values
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_rd", 32'(sd_rd), 32'd0);
        chk("rst_wr", 32'(sd_wr), 32'd0);
        chk("rst_lba", sd_lba, 32'd0);
        chk("rst_blk", 32'(sd_blk_cnt), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_tmo", 32'(timeout), 32'd0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Single read request from unit 1
        req_lba     = {32'h0000_1234, 32'h0000_0000};
        req_blk_cnt = {6'd3, 6'd0};
        req_rd      = 2'b10;
        @(negedge clk_sys);
        chk("t1_rd", 32'(sd_rd), 32'd1);
        chk("t1_lba", sd_lba, 32'h0000_1234);
        chk("t1_blk", 32'(sd_blk_cnt), 32'd3);
        chk("t1_grant", 32'(grant), 32'd2);
        chk("t1_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk_sys);
        chk("t1_hold", 32'(sd_rd), 32'd1);
        sd_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t1_ack", 32'(req_ack), 32'd2);
            if (i >= 1) chk("t1_rd_drop", 32'(sd_rd), 32'd0);
            if (i == 0) req_rd = 2'b00;
            @(negedge clk_sys);
        end
        sd_ack = 1'b0;
        #1;
        chk("t1_ack_off", 32'(req_ack), 32'd0);
        @(negedge clk_sys);
        chk("t1_release", 32'(busy), 32'd1);
        @(negedge clk_sys);
        chk("t1_done", 32'(busy), 32'd0);
        chk("t1_grant0", 32'(grant), 32'd0);

        // Contention: both units hold read; rotation gives 01, 10, 01
        req_rd = 2'b11;
        do_xfer("c0", 2'b01, 1'b1, 1'b0, 8'h00, 2'b00);
        do_xfer("c1", 2'b10, 1'b1, 1'b0, 8'h00, 2'b00);
        do_xfer("c2", 2'b01, 1'b1, 1'b0, 8'h00, 2'b11);

        // Isolation: spurious ack in IDLE, then rd+wr on unit 1 -> read only
        req_buff_din = {8'h3C, 8'hA5};
        sd_ack = 1'b1;
        #1;
        chk("iso_ack", 32'(req_ack), 32'd0);
        @(negedge clk_sys);
        chk("iso_busy", 32'(busy), 32'd0);
        chk("iso_din", 32'(sd_buff_din), 32'd0);
        sd_ack = 1'b0;
        req_rd = 2'b10;
        req_wr = 2'b10;
        do_xfer("rw", 2'b10, 1'b1, 1'b0, 8'h3C, 2'b10);

        // Write path from unit 0
        req_wr = 2'b01;
        do_xfer("wr", 2'b01, 1'b0, 1'b1, 8'hA5, 2'b01);
        chk("wr_idle_din", 32'(sd_buff_din), 32'd0);

        // Reset during the first ack cycle of a unit-1 read
        req_rd = 2'b10;
        repeat (2) @(negedge clk_sys);
        chk("rx_grant", 32'(grant), 32'd2);
        sd_ack = 1'b1;
        #2;
        chk("rx_ack", 32'(req_ack), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("rx_rd", 32'(sd_rd), 32'd0);
        chk("rx_grant0", 32'(grant), 32'd0);
        chk("rx_ack0", 32'(req_ack), 32'd0);
        chk("rx_busy", 32'(busy), 32'd0);
        sd_ack = 1'b0;
        req_rd = 2'b11;
        @(negedge clk_sys);
        reset_n = 1'b1;
        do_xfer("rx_after", 2'b01, 1'b1, 1'b0, 8'hA5, 2'b11);
        chk("end_tmo", 32'(timeout), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
